spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_req_arbiter_if.sv | 35 +++
 rtl/spi_req_arbiter_rr_select.sv | 34 +++
 rtl/spi_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_req_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI request arbiter: FSM encoding and default timeout.
package spi_pkg;

    // Arbiter FSM, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_DONE      = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    // Cycles allowed for the SPI master to raise busy after a start strobe.
    localparam int TIMEOUT_DEFAULT = 8;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester and SPI-master side signals of the arbiter.
// Handshake: a requester raises i_req[k] and holds it (with its i_tx_data slice)
// until o_done[k] pulses; o_rx_data/o_err are valid in that o_done cycle.
// Towards the SPI master, o_spi_tx_rx is a one-cycle start strobe and
// i_spi_rx_data is valid once i_spi_busy falls.
interface spi_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*DW-1:0] i_tx_data;
    logic [N_REQ-1:0]    o_grant;
    logic [N_REQ-1:0]    o_done;
    logic                o_err;
    logic [DW-1:0]       o_rx_data;
    logic                o_spi_tx_rx;
    logic [DW-1:0]       o_spi_tx_data;
    logic                i_spi_busy;
    logic [DW-1:0]       i_spi_rx_data;
    spi_pkg::state_t     o_dbg_state;

    // Arbiter view.
    modport master (
        input  i_req, i_tx_data, i_spi_busy, i_spi_rx_data,
        output o_grant, o_done, o_err, o_rx_data, o_spi_tx_rx, o_spi_tx_data,
        output o_dbg_state
    );

    // Environment view (requesters plus SPI master).
    modport slave (
        output i_req, i_tx_data, i_spi_busy, i_spi_rx_data,
        input  o_grant, o_done, o_err, o_rx_data, o_spi_tx_rx, o_spi_tx_data,
        input  o_dbg_state
    );
endinterface

// File: rtl/spi_req_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    int   cand;
    logic found;

    // Scan N positions starting at ptr; the first requester hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between N_REQ requesters with round-robin fairness,
// a busy-rise timeout, and fully registered outputs.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    spi_req_arbiter_if.master bus
);

    localparam int IW = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_inc;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic [DW-1:0]      rx_data_q, rx_data_d;
    logic [DW-1:0]      tx_data_q, tx_data_d;
    logic               tx_rx_q, tx_rx_d;

    logic [N_REQ-1:0]   sel_grant;
    logic [IW-1:0]      sel_idx;

    rr_select #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_select (
        .req   (bus.i_req),
        .ptr   (rr_ptr_q),
        .grant (sel_grant),
        .index (sel_idx)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so the flops below drive the ports directly.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        rx_data_d = rx_data_q;
        tx_data_d = tx_data_q;
        tx_rx_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A foreign transfer on the bus blocks any new grant.
                if ((|bus.i_req) && !bus.i_spi_busy) begin
                    state_d   = ST_START;
                    grant_d   = sel_grant;
                    owner_d   = sel_idx;
                    tx_data_d = bus.i_tx_data[int'(sel_idx)*DW +: DW];
                    tx_rx_d   = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_inc;
                if (bus.i_spi_busy) begin
                    state_d = ST_WAIT_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    // Master never started: complete with an error and no data.
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    done_d    = grant_q;
                    err_d     = 1'b1;
                    rx_data_d = '0;
                end
            end
            ST_WAIT_IDLE: begin
                if (!bus.i_spi_busy) begin
                    state_d   = ST_DONE;
                    done_d    = grant_q;
                    rx_data_d = bus.i_spi_rx_data;
                end
            end
            ST_DONE: begin
                state_d  = ST_GAP;
                grant_d  = '0;
                rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
            tx_data_q <= '0;
            tx_rx_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_data_q <= rx_data_d;
            tx_data_q <= tx_data_d;
            tx_rx_q   <= tx_rx_d;
        end
    end

    assign bus.o_grant       = grant_q;
    assign bus.o_done        = done_q;
    assign bus.o_err         = err_q;
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_spi_tx_rx   = tx_rx_q;
    assign bus.o_spi_tx_data = tx_data_q;
    assign bus.o_dbg_state   = state_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a loopback SPI master model and
// a start/done scoreboard.
module tb_spi_req_arbiter;
    import spi_pkg::*;

    localparam int N_REQ    = 4;
    localparam int DW       = 8;
    localparam int TIMEOUT  = 8;
    localparam int BUSY_LEN = 4;
    localparam int W        = N_REQ + DW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus signals ----------------
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*DW-1:0] tx_data = '0;
    logic                foreign_busy = 1'b0;
    logic                model_busy = 1'b0;
    logic [DW-1:0]       model_rx = '0;
    logic                spi_en = 1'b1;

    spi_req_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    assign bus.i_req         = req;
    assign bus.i_tx_data     = tx_data;
    assign bus.i_spi_busy    = model_busy | foreign_busy;
    assign bus.i_spi_rx_data = model_rx;

    spi_req_arbiter #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_start_q[$];
    logic [W-1:0] exp_done_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int last_start_cyc = 0;
    int last_done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SPI master model (loopback) ----------------
    int m_phase = 0;
    int m_cnt = 0;
    logic [DW-1:0] m_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_busy = 1'b0;
                m_phase = 0;
                m_cnt = 0;
            end else begin
                case (m_phase)
                    0: if (spi_en && bus.o_spi_tx_rx) begin
                        m_data = bus.o_spi_tx_data;
                        m_cnt = 0;
                        m_phase = 1;
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == 2) begin
                            model_busy = 1'b1;
                            m_cnt = 0;
                            m_phase = 2;
                        end
                    end
                    default: begin
                        m_cnt++;
                        if (m_cnt == BUSY_LEN) begin
                            model_rx = m_data;
                            model_busy = 1'b0;
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("grant_onehot", ($countones(bus.o_grant) <= 1), 1);
                chk("done_onehot", ($countones(bus.o_done) <= 1), 1);
                chk("err_without_done", (bus.o_err && !(|bus.o_done)), 0);
                if (bus.o_spi_tx_rx) begin
                    last_start_cyc = cyc;
                    if (exp_start_q.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                    end else begin
                        e = exp_start_q.pop_front();
                        chk("start_grant", bus.o_grant, e[W-1 -: N_REQ]);
                        chk("start_tx_data", bus.o_spi_tx_data, e[DW:1]);
                    end
                end
                if (|bus.o_done) begin
                    last_done_cyc = cyc;
                    done_seen++;
                    if (exp_done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_done_q.pop_front();
                        chk("done_vec", bus.o_done, e[W-1 -: N_REQ]);
                        chk("done_rx_data", bus.o_rx_data, e[DW:1]);
                        chk("done_err", bus.o_err, e[0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_slice(input int k, input logic [DW-1:0] d);
        tx_data[k*DW +: DW] = d;
    endtask

    task automatic push_xfer(input logic [N_REQ-1:0] vec, input logic [DW-1:0] txd,
                             input logic [DW-1:0] rxd, input logic err);
        exp_start_q.push_back({vec, txd, 1'b0});
        exp_done_q.push_back({vec, rxd, err});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        foreign_busy = 1'b0;
        spi_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for n done pulses; optionally drop the finished requester's req.
    task automatic wait_dones(input int n, input logic drop);
        int target;
        int budget;
        target = done_seen + n;
        budget = 0;
        while (done_seen < target && budget < 2000) begin
            @(negedge clk);
            #1;
            if (drop && (|bus.o_done)) req = req & ~bus.o_done;
            budget++;
        end
        if (done_seen < target) chk("wait_done_budget", done_seen, target);
    endtask

    task automatic wait_state(input state_t st);
        int budget;
        budget = 0;
        while (bus.o_dbg_state != st && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("wait_state", bus.o_dbg_state, st);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, bus.o_grant, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_err"}, bus.o_err, 0);
        chk({tag, "_rx_data"}, bus.o_rx_data, 0);
        chk({tag, "_tx_data"}, bus.o_spi_tx_data, 0);
        chk({tag, "_tx_rx"}, bus.o_spi_tx_rx, 0);
        chk({tag, "_state"}, bus.o_dbg_state, ST_IDLE);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single request with loopback; tx data changed after grant.
        do_reset();
        set_slice(1, 8'hA5);
        push_xfer(4'b0010, 8'hA5, 8'hA5, 1'b0);
        req = 4'b0010;
        wait_state(ST_WAIT_BUSY);
        set_slice(1, 8'h00);
        wait_state(ST_WAIT_IDLE);
        chk("tx_data_stable", bus.o_spi_tx_data, 8'hA5);
        wait_dones(1, 1'b1);
        repeat (4) @(negedge clk);

        // Contention: all four held, order 0,1,2,3,0.
        do_reset();
        set_slice(0, 8'h11); set_slice(1, 8'h22); set_slice(2, 8'h33); set_slice(3, 8'h44);
        push_xfer(4'b0001, 8'h11, 8'h11, 1'b0);
        push_xfer(4'b0010, 8'h22, 8'h22, 1'b0);
        push_xfer(4'b0100, 8'h33, 8'h33, 1'b0);
        push_xfer(4'b1000, 8'h44, 8'h44, 1'b0);
        push_xfer(4'b0001, 8'h11, 8'h11, 1'b0);
        req = 4'b1111;
        wait_dones(5, 1'b0);
        req = '0;
        repeat (6) @(negedge clk);

        // Timeout: master never raises busy.
        do_reset();
        spi_en = 1'b0;
        set_slice(0, 8'h5A);
        push_xfer(4'b0001, 8'h5A, 8'h00, 1'b1);
        req = 4'b0001;
        wait_dones(1, 1'b1);
        chk("timeout_latency", last_done_cyc - (last_start_cyc + 1), TIMEOUT);
        spi_en = 1'b1;
        repeat (4) @(negedge clk);

        // Withdrawal in WAIT_IDLE; next grants follow rr_ptr (3 then 0).
        do_reset();
        set_slice(2, 8'hC3); set_slice(3, 8'hD4); set_slice(0, 8'hE5);
        push_xfer(4'b0100, 8'hC3, 8'hC3, 1'b0);
        push_xfer(4'b1000, 8'hD4, 8'hD4, 1'b0);
        push_xfer(4'b0001, 8'hE5, 8'hE5, 1'b0);
        req = 4'b0100;
        wait_state(ST_WAIT_IDLE);
        req = 4'b1001;
        wait_dones(3, 1'b1);
        repeat (4) @(negedge clk);

        // Foreign busy blocks grant for 20 cycles.
        do_reset();
        foreign_busy = 1'b1;
        set_slice(2, 8'h77);
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("foreign_busy_grant", bus.o_grant, 0);
        end
        push_xfer(4'b0100, 8'h77, 8'h77, 1'b0);
        foreign_busy = 1'b0;
        wait_dones(1, 1'b1);
        repeat (4) @(negedge clk);

        // Reset during WAIT_IDLE: abort, no done, then index 0 first.
        do_reset();
        set_slice(1, 8'h99); set_slice(0, 8'h5C);
        exp_start_q.push_back({4'b0010, 8'h99, 1'b0});
        req = 4'b0010;
        wait_state(ST_WAIT_IDLE);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        chk_all_zero("midreset_hold");
        rst_n = 1'b1;
        push_xfer(4'b0001, 8'h5C, 8'h5C, 1'b0);
        push_xfer(4'b0010, 8'h99, 8'h99, 1'b0);
        req = 4'b0011;
        wait_dones(2, 1'b1);
        repeat (10) @(negedge clk);

        chk("start_q_empty", exp_start_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
